// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: FSM state encoding,
// default widths and the layout of a song ROM word.
package song_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAYING,
    S_PAUSED,
    S_DONE
  } state_e;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_NOTE_W = 6;
  localparam int DEF_DUR_W  = 6;

  // ROM word is {note, duration}: duration in the low bits, note directly above it.
  localparam int DUR_LSB = 0;

  localparam int END_DUR   = 0;
  localparam int REST_NOTE = 0;

endpackage

// File: rtl/song_sequencer_if.sv
// Control and song-ROM signals between the sequencer, its buttons, the song ROM,
// the tone generator and the elapsed-time display.
interface song_sequencer_if
  import song_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W  = DEF_DUR_W
);
  logic                      play_button;
  logic                      reset_button;
  logic [1:0]                song_sel;
  logic [ADDR_W+1:0]         rom_addr;
  logic [NOTE_W+DUR_W-1:0]   rom_data;
  logic [NOTE_W-1:0]         note_out;
  logic                      new_note;
  logic                      play;
  logic                      reset_player;
  logic                      song_done;

  modport master (
    input  play_button, reset_button, song_sel, rom_data,
    output rom_addr, note_out, new_note, play, reset_player, song_done
  );

  modport slave (
    output play_button, reset_button, song_sel, rom_data,
    input  rom_addr, note_out, new_note, play, reset_player, song_done
  );
endinterface

// File: rtl/song_sequencer_beat_timer.sv
// Beat prescaler: counts clk cycles while enabled and ticks once per beat.
module beat_timer #(
  parameter  int unsigned BEAT_CYCLES = 12_500_000,
  localparam int          CNT_W       = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);
  assign cnt  = cnt_q;

endmodule

// File: rtl/song_sequencer.sv
// Walks a song ROM note by note, times each note in beats and drives the
// play / reset_player / song_done controls for the elapsed-time display.
module song_sequencer
  import song_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          NOTE_W      = DEF_NOTE_W,
  parameter int          DUR_W       = DEF_DUR_W,
  parameter int unsigned BEAT_CYCLES = 12_500_000
) (
  input logic               clk,
  input logic               rst,
  song_sequencer_if.master  bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   note_idx_q, note_idx_d;
  logic [1:0]          song_sel_q, song_sel_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [NOTE_W-1:0]   note_out_q, note_out_d;
  logic                new_note_q, new_note_d;
  logic                reset_player_q, reset_player_d;
  logic                song_done_q, song_done_d;

  logic                beat_en, beat_clr, beat_tick;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  assign rom_note = bus.rom_data[DUR_LSB+DUR_W +: NOTE_W];
  assign rom_dur  = bus.rom_data[DUR_LSB +: DUR_W];
  assign beat_en  = (state_q == S_PLAYING);

  beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (beat_en),
    .clr  (beat_clr),
    .tick (beat_tick),
    .cnt  ()
  );

  always_comb begin
    state_d        = state_q;
    note_idx_d     = note_idx_q;
    song_sel_d     = song_sel_q;
    dur_cnt_d      = dur_cnt_q;
    note_out_d     = note_out_q;
    new_note_d     = 1'b0;
    reset_player_d = 1'b0;
    beat_clr       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.play_button) begin
          song_sel_d = bus.song_sel;
          note_idx_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_dur == DUR_W'(END_DUR)) begin
          state_d = S_DONE;
        end else begin
          note_out_d = rom_note;
          dur_cnt_d  = rom_dur;
          beat_clr   = 1'b1;
          new_note_d = 1'b1;
          state_d    = S_PLAYING;
        end
      end
      S_PLAYING: begin
        // Note expiry wins over a pause request landing on the same beat tick.
        if (beat_tick) begin
          dur_cnt_d = dur_cnt_q - DUR_W'(1);
          if (dur_cnt_q == DUR_W'(1)) begin
            if (&note_idx_q) begin
              state_d = S_DONE;
            end else begin
              note_idx_d = note_idx_q + ADDR_W'(1);
              state_d    = S_FETCH;
            end
          end else if (bus.play_button) begin
            state_d = S_PAUSED;
          end
        end else if (bus.play_button) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (bus.play_button) state_d = S_PLAYING;
      end
      S_DONE: begin
        if (bus.play_button) begin
          song_sel_d     = bus.song_sel;
          note_idx_d     = '0;
          reset_player_d = 1'b1;
          state_d        = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.reset_button) begin
      state_d        = S_IDLE;
      note_idx_d     = '0;
      dur_cnt_d      = '0;
      note_out_d     = NOTE_W'(REST_NOTE);
      new_note_d     = 1'b0;
      reset_player_d = 1'b1;
      beat_clr       = 1'b1;
    end

    song_done_d = (state_d == S_DONE) && (state_q != S_DONE);
    if (song_done_d) note_out_d = NOTE_W'(REST_NOTE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      note_idx_q     <= '0;
      song_sel_q     <= '0;
      dur_cnt_q      <= '0;
      note_out_q     <= '0;
      new_note_q     <= 1'b0;
      reset_player_q <= 1'b0;
      song_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      note_idx_q     <= note_idx_d;
      song_sel_q     <= song_sel_d;
      dur_cnt_q      <= dur_cnt_d;
      note_out_q     <= note_out_d;
      new_note_q     <= new_note_d;
      reset_player_q <= reset_player_d;
      song_done_q    <= song_done_d;
    end
  end

  // Song time keeps running through the fetch/load gap between notes.
  assign bus.play         = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                            (state_q == S_PLAYING);
  assign bus.rom_addr     = {song_sel_q, note_idx_q};
  assign bus.note_out     = note_out_q;
  assign bus.new_note     = new_note_q;
  assign bus.reset_player = reset_player_q;
  assign bus.song_done    = song_done_q;

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Upstream control stage for the on-screen song timer.
- Walks a song ROM one note at a time and times each note's duration in beats.
- Drives the `play`, `reset_player` and `song_done` controls that the elapsed-time display consumes.
- Also presents the current note code to the tone generator.

Parameters:
- ADDR_W, 7: note-index width per song (128 notes max).
- NOTE_W, 6: note code width; 0 = rest.
- DUR_W, 6: duration width in beats; a duration of 0 marks end of song.
- BEAT_CYCLES, 25'd12_500_000: clk cycles per beat (125 ms at 100 MHz).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- play_button, in, 1: single-cycle debounced pulse; start / pause / resume.
- reset_button, in, 1: single-cycle pulse; stop and rewind.
- song_sel, in, 2: song select, used as the upper ROM address bits.
- rom_addr, out, ADDR_W+2: {song_sel_q, note_idx} to the song ROM.
- rom_data, in, NOTE_W+DUR_W: {note, duration}; synchronous ROM, valid 1 cycle after the address.
- note_out, out, NOTE_W: current note code; 0 = silent.
- new_note, out, 1: one-cycle pulse when note_out is loaded.
- play, out, 1: song time advancing; gates the time display counter.
- reset_player, out, 1: one-cycle pulse; clears the time display.
- song_done, out, 1: one-cycle pulse on end of song.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; note_idx=0, song_sel_q=0, beat_cnt=0, dur_cnt=0.
  - All outputs 0.
- States: IDLE, FETCH, LOAD, PLAYING, PAUSED, DONE.
- IDLE:
  - play=0, note_out=0.
  - play_button: song_sel_q<=song_sel, note_idx<=0, go to FETCH.
- FETCH:
  - rom_addr is driven from registers (stable). Always go to LOAD next cycle.
- LOAD:
  - If rom_data duration==0: go to DONE.
  - Else: note_out<=note, dur_cnt<=duration, beat_cnt<=0, new_note=1 for the next cycle, go to PLAYING.
- PLAYING:
  - beat_cnt increments each cycle and wraps at BEAT_CYCLES-1 (beat tick).
  - On a tick, dur_cnt decrements.
  - Tick with dur_cnt==1:
    - If note_idx is all-ones, go to DONE (wrap-around is not allowed).
    - Else note_idx++ and go to FETCH.
  - Each note therefore occupies duration*BEAT_CYCLES PLAYING cycles plus 2 fetch cycles.
- play output:
  - play=1 in FETCH, LOAD and PLAYING once started, so song time runs continuously across note boundaries.
  - play=0 in IDLE, PAUSED and DONE.
- Pause:
  - play_button in PLAYING goes to PAUSED.
  - beat_cnt, dur_cnt, note_idx and note_out are held; play=0.
  - play_button in PAUSED returns to PLAYING with counters resumed exactly.
  - play_button in FETCH or LOAD is ignored (window ≤2 cycles).
- DONE:
  - On entry: song_done=1 for exactly one cycle, note_out<=0, play=0.
  - play_button restarts: song_sel_q<=song_sel, note_idx<=0, reset_player pulse, go to FETCH.
- reset_button (any state):
  - Next state IDLE; note_idx, counters and note_out cleared.
  - reset_player=1 for the following cycle.
  - Takes priority over a simultaneous play_button.
- song_sel is sampled only when leaving IDLE or DONE; later changes are ignored until then.
- Output timing: all outputs are registered or decoded from registered state only; rom_addr is purely registered.
- Widths: beat_cnt is $clog2(BEAT_CYCLES) bits; compare against BEAT_CYCLES-1 at full width with no truncation.
- Asserting rst mid-note: immediate return to reset values; no song_done or reset_player pulse is produced.

Decomposition:
- Package song_pkg:
  - State encoding (localparam enum).
  - NOTE_W/DUR_W field positions in the ROM word.
  - END_DUR = 0; REST_NOTE = 0.
- Sub-module beat_timer:
  - Inputs: clk, rst, en, clr.
  - Outputs: tick, plus cnt for debug.
  - Implements the BEAT_CYCLES prescaler; held when en=0, zeroed on clr.
- The FSM and note_idx/dur_cnt registers stay in song_sequencer.

Test Plan (BEAT_CYCLES=4; song 0 ROM = {10,2},{12,1},{0,0}):
- Basic play: play_button pulse at cycle 0.
  - rom_addr=0 in FETCH; new_note and note_out=10 at cycle 3.
  - note_out=12 at cycle 13; song_done pulse at cycle 19; play high cycles 1–18.
- Pause/resume: play_button at cycle 5, then again at cycle 25.
  - play=0 for cycles 6–25; note_out held at 10.
  - Note 12 loads at cycle 33 (20-cycle shift).
- Reset mid-song: reset_button at cycle 7 → IDLE, note_out=0, reset_player=1 at cycle 8, play=0.
  - Simultaneous play_button at cycle 7 is ignored.
- Restart from DONE with song_sel=2: play_button after song_done.
  - reset_player pulse, rom_addr=0x100 in FETCH.
  - Change song_sel to 1 mid-song → rom_addr upper bits stay 2.
- Full ROM without end marker (ADDR_W=2, four notes of duration 1):
  - After note index 3 expires → DONE, song_done pulse; no wrap to index 0.
- Async reset asserted between clock edges during PLAYING:
  - All outputs 0 immediately; no song_done or reset_player pulse afterwards.
